// File: rtl/frame_pkg.sv
// Shared definitions for the frame loader and the downstream min-reduction stage.
package frame_pkg;

    // Default frame geometry, shared with calculate_Min.
    localparam int WORD_WIDTH = 8;
    localparam int DATA_LEN   = 16;

    // Width of a counter that can hold 0..DATA_LEN inclusive.
    localparam int COUNT_W = $clog2(DATA_LEN + 1);

    // Loader state: collecting words, or holding a complete frame.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage : frame_pkg

// File: rtl/word_slot_reg.sv
// One frame slot: a WIDTH-bit register with write-enable and synchronous clear.
// Clear wins over a write on the same edge.
module word_slot_reg
    import frame_pkg::*;
#(
    parameter int WIDTH = frame_pkg::WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] slot_q;
    logic [WIDTH-1:0] slot_d;

    // Next value: clear beats write, otherwise hold.
    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end else if (we) begin
            slot_d = d;
        end
    end

    // Slot storage with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q = slot_q;

endmodule : word_slot_reg

// File: rtl/data_frame_loader.sv
// Serial-to-parallel frame loader. Words arrive one per cycle over a
// valid/ready handshake and are packed into DATA_LEN slots; the complete
// frame is held stable on `data` until the consumer releases it.
//
// Handshakes: a word moves on a rising edge where in_valid=1 and in_ready=1;
// a frame is released on a rising edge where frame_valid=1 and frame_ready=1.
// Neither ready nor valid output depends combinationally on any input; both
// decode the state register only.
module data_frame_loader
    import frame_pkg::*;
#(
    parameter int WORD_WIDTH = frame_pkg::WORD_WIDTH,
    parameter int DATA_LEN   = frame_pkg::DATA_LEN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            in_data,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [WORD_WIDTH*DATA_LEN-1:0]   data,
    output logic [$clog2(DATA_LEN+1)-1:0]    count
);

    localparam int CNT_W = $clog2(DATA_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             accept;

    // A word is taken only while filling, and never on a clearing edge.
    assign accept = in_valid && (state_q == FILL) && !clear;

    // Next-state and counter update; clear overrides accept and release.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = FILL;
            count_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        count_d = count_q + ONE;
                        if (count_q == LAST_SLOT) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    // Old slot contents stay; they are overwritten as new words land.
                    if (frame_ready) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Handshake outputs decode the state register directly.
    assign in_ready    = (state_q == FILL);
    assign frame_valid = (state_q == FULL);
    assign count       = count_q;

    // One slot register per word; the slot addressed by count is written on accept.
    for (genvar k = 0; k < DATA_LEN; k++) begin : g_slot
        logic                  slot_we;
        logic [WORD_WIDTH-1:0] slot_q;

        assign slot_we = accept && (count_q == CNT_W'(k));

        word_slot_reg #(
            .WIDTH (WORD_WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .we    (slot_we),
            .d     (in_data),
            .q     (slot_q)
        );

        assign data[WORD_WIDTH*k +: WORD_WIDTH] = slot_q;
    end

endmodule : data_frame_loader

// File: tb/tb_data_frame_loader.sv
// Bench for data_frame_loader: directed frames, backpressure, gapped input,
// clear priority, asynchronous reset and a min-reduction check on the frame.
module tb_data_frame_loader;
    import frame_pkg::*;

    localparam int WW = 8;
    localparam int DL = 16;
    localparam int FW = WW * DL;
    localparam int CW = $clog2(DL + 1);

    typedef logic [WW-1:0] wvec_t [DL];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [FW-1:0] data;
    logic [CW-1:0] count;

    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            exp_cnt = 0;
    logic [FW-1:0] exp_q[$];
    logic          fv_prev;

    // Clock
    always #5 clk = ~clk;

    data_frame_loader #(
        .WORD_WIDTH (WW),
        .DATA_LEN   (DL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .data        (data),
        .count       (count)
    );

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] min_of(input logic [FW-1:0] d);
        logic [WW-1:0] m;
        m = '1;
        for (int i = 0; i < DL; i++) begin
            if (d[WW*i +: WW] < m) m = d[WW*i +: WW];
        end
        return m;
    endfunction

    // Driver: one accepted word, then `gap` idle cycles with junk on in_data.
    task automatic send_word(input logic [WW-1:0] w, input int gap);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        exp_cnt++;
        chk("count after accept", FW'(count), FW'(exp_cnt));
        chk("frame_valid after accept", FW'(frame_valid), FW'(exp_cnt == DL));
        for (int g = 0; g < gap; g++) begin
            step();
            chk("count idle", FW'(count), FW'(exp_cnt));
            chk("frame_valid idle", FW'(frame_valid), FW'(exp_cnt == DL));
        end
    endtask

    // Driver: full frame; the expected packed frame goes to the scoreboard.
    task automatic send_frame(input wvec_t w, input int gap);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < DL; i++) f[WW*i +: WW] = w[i];
        exp_q.push_back(f);
        for (int i = 0; i < DL; i++) send_word(w[i], gap);
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        exp_cnt = 0;
        chk("count after release", FW'(count), FW'(0));
        chk("frame_valid after release", FW'(frame_valid), FW'(0));
        chk("in_ready after release", FW'(in_ready), FW'(1));
    endtask

    // Monitor: each rising frame_valid pops one expected frame.
    initial begin
        logic [FW-1:0] f;
        fv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_valid && !fv_prev) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected frame: got %0h expected none", data);
                end else begin
                    f = exp_q.pop_front();
                    chk("frame data", data, f);
                    chk("frame count", FW'(count), FW'(DL));
                end
            end
            fv_prev = frame_valid;
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench timed out");
    end

    // Stimulus
    initial begin
        wvec_t         w;
        logic [FW-1:0] hold_f;
        logic [FW-1:0] bp_f;

        rst_n       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        frame_ready = 1'b0;
        #3;
        chk("reset count", FW'(count), FW'(0));
        chk("reset frame_valid", FW'(frame_valid), FW'(0));
        chk("reset in_ready", FW'(in_ready), FW'(1));
        chk("reset data", data, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("no accept after reset release", FW'(count), FW'(0));

        // Fill and hold: 0x10..0x1F back to back.
        for (int i = 0; i < DL; i++) w[i] = 8'h10 + WW'(i);
        send_frame(w, 0);
        hold_f = 128'h1F1E1D1C1B1A19181716151413121110;
        chk("fill data[7:0]", FW'(data[7:0]), FW'(8'h10));
        chk("fill data[127:120]", FW'(data[127:120]), FW'(8'h1F));
        chk("fill in_ready", FW'(in_ready), FW'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold frame_valid", FW'(frame_valid), FW'(1));
            chk("hold data", data, hold_f);
            chk("hold count", FW'(count), FW'(DL));
            chk("hold in_ready", FW'(in_ready), FW'(0));
        end

        // Backpressure: 0xAA offered while full must not be written.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp data frozen", data, hold_f);
            chk("bp count frozen", FW'(count), FW'(DL));
        end
        bp_f = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1AA;
        exp_q.push_back(bp_f);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        exp_cnt = 0;
        chk("bp release count", FW'(count), FW'(0));
        chk("bp release in_ready", FW'(in_ready), FW'(1));
        chk("bp release data kept", data, hold_f);
        step();
        in_valid = 1'b0;
        exp_cnt = 1;
        chk("bp AA count", FW'(count), FW'(1));
        chk("bp AA slot0", FW'(data[7:0]), FW'(8'hAA));
        chk("bp old slot1", FW'(data[15:8]), FW'(8'h11));
        for (int i = 1; i < DL; i++) send_word(8'hA0 + WW'(i), 0);
        release_frame();

        // Gapped input: valid toggles 1/0, last accept on the 31st edge.
        for (int i = 0; i < DL; i++) w[i] = 8'h30 + WW'(i);
        send_frame(w, 1);
        release_frame();

        // Clear while filling, together with a valid word.
        for (int i = 0; i < 7; i++) send_word(8'h50 + WW'(i), 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 0;
        chk("clear fill count", FW'(count), FW'(0));
        chk("clear fill data", data, '0);
        chk("clear fill in_ready", FW'(in_ready), FW'(1));
        step();
        chk("clear fill word dropped", data, '0);

        // Clear together with release while full.
        for (int i = 0; i < DL; i++) w[i] = 8'h60 + WW'(i);
        send_frame(w, 0);
        clear       = 1'b1;
        frame_ready = 1'b1;
        step();
        clear       = 1'b0;
        frame_ready = 1'b0;
        exp_cnt     = 0;
        chk("clear full count", FW'(count), FW'(0));
        chk("clear full data", data, '0);
        chk("clear full frame_valid", FW'(frame_valid), FW'(0));
        chk("clear full in_ready", FW'(in_ready), FW'(1));

        // Asynchronous reset between edges after 9 words.
        for (int i = 0; i < 9; i++) send_word(8'h70 + WW'(i), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async count", FW'(count), FW'(0));
        chk("async frame_valid", FW'(frame_valid), FW'(0));
        chk("async in_ready", FW'(in_ready), FW'(1));
        chk("async data", data, '0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        step();
        chk("async idle after release", FW'(count), FW'(0));

        // Downstream min-reduction on a held frame.
        w = '{8'h80, 8'h05, 8'hFF, 8'hC3, 8'h99, 8'h41, 8'h7E, 8'h20,
              8'hD0, 8'h11, 8'hEE, 8'h6A, 8'hB2, 8'h0C, 8'h57, 8'h3C};
        send_frame(w, 0);
        for (int i = 0; i < 3; i++) begin
            chk("min while valid", FW'(min_of(data)), FW'(8'h05));
            step();
        end
        release_frame();

        repeat (3) step();
        chk("pending frames", FW'(exp_q.size()), FW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_data_frame_loader

// File: doc/data_frame_loader.md
# data_frame_loader

Serial-to-parallel front end for the min-reduction path. It accepts one WORD_WIDTH-bit word per cycle over a valid/ready handshake and packs DATA_LEN words into one flattened frame register. It presents the frame to the downstream combinational `calculate_Min` stage and holds it stable until that consumer releases it. All outputs are registered.

## Interface
- WORD_WIDTH, 8, bits per word
- DATA_LEN, 16, words per frame (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort: drops the partial or held frame
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WORD_WIDTH  incoming word
- frame_valid  output  1  data holds a complete frame
- frame_ready  input  1  consumer has taken the frame
- data  output  WORD_WIDTH*DATA_LEN  flattened frame; word k is at data[WORD_WIDTH*k +: WORD_WIDTH]
- count  output  $clog2(DATA_LEN+1)  number of words stored in the current frame

## Operation
- Two states:
  - FILL: in_ready=1, frame_valid=0.
  - FULL: in_ready=0, frame_valid=1.
- Reset (rst_n=0, asynchronous, any state): FILL, count=0, data=0, in_ready=1, frame_valid=0.
- Accept rule: a word is accepted on the rising edge where in_valid=1 and in_ready=1. It is written to slot `count`, and count increments.
  - The k-th accepted word (k starts at 0) lands in slot k.
  - in_data is ignored when in_valid=0 or in_ready=0.
- FILL→FULL: taken on the edge that accepts the word into slot DATA_LEN-1. count becomes DATA_LEN.
- In FULL:
  - data and count are frozen.
  - in_valid is ignored; the upstream must hold its word until in_ready returns.
- FULL→FILL: taken on the edge where frame_valid=1 and frame_ready=1. count becomes 0.
  - data keeps the old frame contents; slots are overwritten only as new words arrive.
- frame_ready while in FILL: no effect.
- clear=1 at an edge:
  - Highest priority; overrides any accept or release on that edge.
  - Result: FILL, count=0, data=0.
- Stored words are never cleared except by rst_n or clear.

## Timing
- Latency: frame_valid rises in the cycle right after the edge that accepts the last word. The flattened data is complete in that same cycle.
- Throughput:
  - DATA_LEN accepted words per frame.
  - At least one dead cycle per frame: in_ready=0 while FULL.
  - Best case with frame_ready tied high is DATA_LEN+1 cycles per frame.
- No combinational path from any input to any output; in_ready and frame_valid decode the state register only.
- Handshake rules:
  - frame_valid stays high until released.
  - data and count stay stable for every cycle frame_valid=1.
- Reset mid-frame: partial words are discarded and all outputs read reset values in the same cycle rst_n falls.
- Deasserting rst_n synchronously to clk is the integration's job. No accept happens on the first edge after release unless in_valid=1.

## Structure
- Shared package `frame_pkg`:
  - WORD_WIDTH and DATA_LEN defaults, shared with `calculate_Min`.
  - The state enum: FILL=1'b0, FULL=1'b1.
  - COUNT_W = $clog2(DATA_LEN+1).
- Sub-modules:
  - One natural sub-module, `word_slot_reg`: a WORD_WIDTH register with write-enable and synchronous clear, instantiated DATA_LEN times through a generate loop.
  - The FSM and counter stay in the top module.
- At the level above, data connects directly to the `calculate_Min` data input with matching parameters.

## Test plan
- Fill and hold:
  - Stimulus: reset, then feed 16 back-to-back words 0x10..0x1F with frame_ready=0.
  - Required: frame_valid=1 exactly one cycle after the 16th accept, data[7:0]=0x10, data[127:120]=0x1F, count=16, in_ready=0.
  - Required: all of these hold for 5 idle cycles.
- Backpressure:
  - Stimulus: hold in_valid=1 with in_data=0xAA while FULL, then pulse frame_ready=1 for one cycle.
  - Required: 0xAA is not written while FULL.
  - Required: next cycle count=0 and in_ready=1; 0xAA is accepted into slot 0 on the following edge.
- Gapped input:
  - Stimulus: 16 words with in_valid toggling 1/0.
  - Required: count advances only on valid edges; frame completes after 31 cycles with the correct slot order.
- Clear priority:
  - Stimulus: after 7 accepted words, assert clear together with in_valid=1.
  - Required: count=0, data=0, word not stored.
  - Required: repeat with clear in the same cycle as frame_ready in FULL and get the same result.
- Async reset mid-frame:
  - Stimulus: drop rst_n between clock edges after 9 words.
  - Required: count=0, frame_valid=0, in_ready=1, data=0 immediately, without waiting for a clock edge.
- Downstream integration:
  - Stimulus: frame 0x80,0x05,0xFF,…,0x3C (min 0x05) into `calculate_Min`.
  - Required: min=0x05 while frame_valid=1.
